// File: rtl/decade_timer_ctrl_if.sv
// Command/status bundle between the user-side controller and the decade timer.
// The master drives run/pause/clear commands and the terminal value; the slave reports count and status.
interface decade_timer_ctrl_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic [4*DIGITS-1:0]   limit;
    logic [4*DIGITS-1:0]   count;
    logic [1:0]            state;
    logic                  busy;
    logic                  done;
    logic                  wrap;

    modport master (
        output start, stop, clear, limit,
        input  count, state, busy, done, wrap
    );

    modport slave (
        input  start, stop, clear, limit,
        output count, state, busy, done, wrap
    );
endinterface

// File: rtl/decade_timer_ctrl.sv
// Start/stop/clear sequencer for a chain of synchronous BCD digit counters,
// with a clock prescaler and a latched terminal value that raises a done pulse.
module decade_timer_ctrl #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    decade_timer_ctrl_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t         state_q;
    logic [W-1:0]   count_q;
    logic [W-1:0]   limit_q;
    logic [PW-1:0]  presc_q;
    logic           busy_q;
    logic           done_q;
    logic           wrap_q;

    logic [W-1:0]   count_d;
    logic           carry;
    logic           all_nines;
    logic           tick;

    // Ripple-free BCD increment: a digit advances only while every lower digit is 9.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_d = count_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        // A carry out of the top digit means the whole chain was all 9s.
        all_nines = carry;
    end

    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST) && !bus.clear && !bus.stop;

    // NOTE: reset is in the sensitivity list so it takes effect without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            presc_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        count_q <= '0;
                    end else if (!bus.stop && bus.start) begin
                        limit_q <= bus.limit;
                        presc_q <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.clear) begin
                        count_q <= '0;
                        presc_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bus.stop) begin
                        state_q <= PAUSE;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        presc_q <= '0;
                        count_q <= count_d;
                        wrap_q  <= all_nines;
                        // Match only on the post-increment value; a limit with a non-BCD digit never hits.
                        if (count_d == limit_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.clear) begin
                        count_q <= '0;
                        presc_q <= '0;
                        state_q <= IDLE;
                    end else if (!bus.stop && bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.clear) begin
                        count_q <= '0;
                        presc_q <= '0;
                        state_q <= IDLE;
                    end else if (!bus.stop && bus.start) begin
                        count_q <= '0;
                        presc_q <= '0;
                        limit_q <= bus.limit;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.state = state_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.wrap  = wrap_q;
endmodule
